// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory with a
// parameterised access latency, ALU pass-through and register-writeback bundle.
module mem_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m_IR,
    input  logic        valid_in,
    input  logic [31:0] saida,
    input  logic [9:0]  mem_dest,
    output logic        stall,
    output logic [31:0] w_IR,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLoad  = 6'b100011;
    localparam logic [5:0] OpStore = 6'b101011;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;

    localparam bit         SingleCycle = (LATENCY == 1);
    localparam logic [3:0] CntInit     = 4'(LATENCY - 1);

    typedef enum logic {StIdle, StAccess} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] ir_q;
    logic [31:0] saida_q;
    logic [9:0]  dest_q;
    logic [31:0] mem_q [DEPTH];

    logic [31:0] cur_ir;
    logic [31:0] cur_saida;
    logic [9:0]  cur_dest;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_rtype;
    logic        is_addi;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        retire;
    logic        do_store;
    logic [4:0]  nxt_reg;
    logic [31:0] nxt_data;
    logic        nxt_we;
    logic [9:0]  unused_dest;

    assign stall = (state_q == StAccess);

    // While an access is in flight the latched operands drive decode; inputs are ignored.
    always_comb begin
        cur_ir    = stall ? ir_q : m_IR;
        cur_saida = stall ? saida_q : saida;
        cur_dest  = stall ? dest_q : mem_dest;

        opcode   = cur_ir[31:26];
        funct    = cur_ir[5:0];
        is_rtype = (opcode == OpRType) && ((funct == FnAdd) || (funct == FnSub));
        is_addi  = (opcode == OpAddi);
        is_load  = (opcode == OpLoad);
        is_store = (opcode == OpStore);
        is_mem   = is_load || is_store;

        nxt_reg = 5'd0;
        if (is_load) begin
            nxt_reg = cur_dest[4:0];
        end else if (is_addi) begin
            nxt_reg = cur_ir[20:16];
        end else if (is_rtype) begin
            nxt_reg = cur_ir[15:11];
        end
        nxt_data = is_load ? mem_q[cur_saida[ADDR_W-1:0]] : cur_saida;
        nxt_we   = (is_rtype || is_addi || is_load) && (nxt_reg != 5'd0);

        retire = 1'b0;
        if (state_q == StIdle) begin
            retire = valid_in && (!is_mem || SingleCycle);
        end else begin
            retire = (cnt_q == 4'd1);
        end
        do_store = retire && is_store;
    end

    assign unused_dest = cur_dest;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            ir_q     <= 32'd0;
            saida_q  <= 32'd0;
            dest_q   <= 10'd0;
            w_IR     <= 32'd0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_reg   <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            w_IR     <= 32'd0;
            if (retire) begin
                wb_valid <= 1'b1;
                wb_we    <= nxt_we;
                wb_reg   <= nxt_reg;
                wb_data  <= nxt_data;
                w_IR     <= cur_ir;
            end
            unique case (state_q)
                StIdle: begin
                    if (valid_in && is_mem && !SingleCycle) begin
                        ir_q    <= m_IR;
                        saida_q <= saida;
                        dest_q  <= mem_dest;
                        cnt_q   <= CntInit;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_store) begin
            mem_q[cur_dest[ADDR_W-1:0]] <= cur_saida;
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline; the consumer of the ALU stage's result/destination pair (saida, mem_dest).
- Holds a word-addressed data memory. Performs loads and stores with a parameterised access latency, and stalls upstream while an access is in flight.
- Passes ALU results through to writeback and produces the register-writeback bundle plus the W-stage instruction used by the ALU scoreboard.

Parameters:
- DEPTH, 256, number of 32-bit data-memory words (power of two).
- ADDR_W, 8, log2(DEPTH); low bits of the address used for indexing.
- LATENCY, 2, cycles a load/store occupies the stage (legal range 1..15).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- m_IR  in  32  instruction currently presented to MEM.
- valid_in  in  1  m_IR/saida/mem_dest are valid this cycle.
- saida  in  32  ALU result. ALU ops: result. Load: address. Store: store data.
- mem_dest  in  10  Load: destination register in [4:0]. Store: word address. ALU ops: ignored.
- stall  out  1  stage busy; upstream holds m_IR/saida/mem_dest/valid_in unchanged.
- w_IR  out  32  instruction retired to writeback this cycle (0 = bubble).
- wb_valid  out  1  w_IR/wb_* valid this cycle.
- wb_we  out  1  register-file write enable.
- wb_reg  out  5  register-file write address.
- wb_data  out  32  register-file write data (also the saidaULA_wb forwarding value).

Behaviour:
- Decode (from m_IR):
  - R-type add/sub: opcode 000000, funct 100000/100010. wb_reg = IR[15:11], wb_data = saida.
  - addi: opcode 001000. wb_reg = IR[20:16], wb_data = saida.
  - load: opcode 100011. wb_reg = mem_dest[4:0], wb_data = mem[saida[ADDR_W-1:0]].
  - store: opcode 101011. mem[mem_dest[ADDR_W-1:0]] <= saida; no register write.
  - Any other opcode/funct: bubble. Consumes one cycle, wb_valid=1, wb_we=0, w_IR = m_IR.
- Address bits above ADDR_W are ignored; addresses wrap modulo DEPTH.
- wb_we = 1 only for add/sub/addi/load with wb_reg != 0. A write to register 0 is retired with wb_we=0.
- Reset (async, reset low):
  - state=IDLE, counter=0, stall=0, wb_valid=0, wb_we=0, wb_reg=0, wb_data=0, w_IR=0.
  - All memory words cleared to 0.
  - Reset during ACCESS aborts the access; a pending store is not performed.
- FSM states: IDLE, ACCESS.
- IDLE:
  - stall=0.
  - Rising edge with valid_in=1 and an ALU/bubble op: register the wb outputs, w_IR = m_IR, wb_valid=1. Latency 1.
  - Rising edge with valid_in=1 and a load/store, LATENCY=1: perform the access at this edge and register the wb outputs. Stay in IDLE.
  - Rising edge with valid_in=1 and a load/store, LATENCY>1: latch m_IR, saida, mem_dest; counter = LATENCY-1; go to ACCESS; wb_valid=0, wb_we=0, w_IR=0.
  - Rising edge with valid_in=0: wb_valid=0, wb_we=0, w_IR=0.
- ACCESS:
  - stall=1, decoded combinationally from state. Inputs are ignored.
  - Each edge decrements counter.
  - On the edge where counter==1: perform the access using the latched values, register the wb outputs (wb_valid=1, w_IR = latched IR), return to IDLE.
  - Each load/store therefore retires LATENCY cycles after acceptance, with stall high for LATENCY-1 cycles.
- Ordering: accesses complete in program order. A load accepted after a store reads the stored value, including the same address on the next accepted instruction.
- wb outputs persist one cycle only. They return to wb_valid=0, wb_we=0, w_IR=0 on the next edge unless another instruction retires.

Test Plan:
- Reset with data: reset low mid-ACCESS of store saida=0xDEADBEEF, mem_dest=5 -> stall=0, wb_valid=0, w_IR=0. A subsequent load of address 5 into r3 returns wb_data=0.
- ALU pass-through: addi r4 (IR[20:16]=4), saida=0x0000002A -> next edge wb_valid=1, wb_we=1, wb_reg=4, wb_data=0x2A, w_IR=m_IR. stall never asserted.
- Store then load, LATENCY=2:
  - Store mem_dest=7, saida=0x12345678 -> stall high 1 cycle; retires with wb_we=0.
  - Load saida=7, mem_dest=9 -> stall high 1 cycle; retires with wb_reg=9, wb_data=0x12345678.
- Wrap-around: store mem_dest=0x105 (DEPTH=256), saida=0xA5A5A5A5 -> a load from saida=5 returns 0xA5A5A5A5.
- r0 suppression: add with IR[15:11]=0, saida=0xFFFFFFFF -> wb_valid=1, wb_we=0. A load with mem_dest=0 also gives wb_we=0.
- Stall holding, LATENCY=4: back-to-back load then add -> stall high 3 cycles; add ignored until stall falls; the add retires exactly 1 cycle after the load's retirement.
